// File: rtl/dso_cmd_pkg.sv
// Shared types and constants for the DSO_dig host command path: receive
// state encoding, command opcodes, response codes and shadow lane helper.
package dso_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_B1  = 2'd0,
    WAIT_B2  = 2'd1,
    WAIT_B3  = 2'd2,
    CMD_HOLD = 2'd3
  } rx_state_e;

  localparam logic [7:0] DUMP_CH  = 8'h01;
  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] TRIG_LVL = 8'h03;
  localparam logic [7:0] TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC  = 8'h05;
  localparam logic [7:0] TRIG_CFG = 8'h06;
  localparam logic [7:0] TRIG_RD  = 8'h07;
  localparam logic [7:0] EEP_WRT  = 8'h08;
  localparam logic [7:0] EEP_RD   = 8'h09;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  // Lane 0 is the opcode [23:16], lane 1 is [15:8], lane 2 is [7:0].
  function automatic logic [23:0] put_lane(input logic [23:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [23:0] r;
    r = word;
    case (lane)
      2'd0:    r[23:16] = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[7:0]   = b;
      default: r        = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response serialiser: hands one dispatcher byte at a time to the UART
// transmitter and reports completion, masking stale tx_done after a start.
module resp_tx_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp_data,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       resp_sent,
  output logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       trmt
);

  logic [7:0] tx_data_r, tx_data_nxt_s;
  logic       trmt_r, blank_r, tx_busy_r, tx_busy_nxt_s, resp_sent_r;
  logic       accept_s, done_s;

  assign accept_s = send_resp && !tx_busy_r;
  // tx_done still reflects the previous byte until the UART has seen trmt.
  assign done_s   = tx_busy_r && tx_done && !trmt_r && !blank_r;

  // Next-value logic for the transmit data and busy flag.
  always_comb begin
    tx_data_nxt_s = tx_data_r;
    tx_busy_nxt_s = tx_busy_r;
    if (accept_s) begin
      tx_data_nxt_s = resp_data;
      tx_busy_nxt_s = 1'b1;
    end else if (done_s) begin
      tx_busy_nxt_s = 1'b0;
    end else begin
      tx_busy_nxt_s = tx_busy_r;
    end
  end

  // Response path registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_r   <= 8'h00;
      trmt_r      <= 1'b0;
      blank_r     <= 1'b0;
      tx_busy_r   <= 1'b0;
      resp_sent_r <= 1'b0;
    end else begin
      tx_data_r   <= tx_data_nxt_s;
      trmt_r      <= accept_s;
      blank_r     <= trmt_r;
      tx_busy_r   <= tx_busy_nxt_s;
      resp_sent_r <= done_s;
    end
  end

  assign tx_data   = tx_data_r;
  assign trmt      = trmt_r;
  assign tx_busy   = tx_busy_r;
  assign resp_sent = resp_sent_r;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles three UART bytes into a 24-bit host command held under a
// ready/clear handshake, with inter-byte timeout; forwards responses back.
module uart_cmd_assembler
  import dso_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_timeout,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  rx_state_e        state_r, state_nxt_s;
  logic [23:0]      shadow_r, shadow_nxt_s;
  logic [23:0]      cmd_r, cmd_nxt_s;
  logic             cmd_rdy_r, cmd_rdy_nxt_s;
  logic             clr_rx_rdy_r, cmd_timeout_r;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             capture_s, timeout_s;

  // The consume pulse masks rx_rdy so a slowly falling rdy is not re-captured.
  assign capture_s = (state_r != CMD_HOLD) && rx_rdy && !clr_rx_rdy_r;
  assign timeout_s = ((state_r == WAIT_B2) || (state_r == WAIT_B3)) &&
                     (cnt_r == CNT_MAX) && !capture_s;

  // Receive FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WAIT_B1;
      shadow_r      <= 24'h000000;
      cmd_r         <= 24'h000000;
      cmd_rdy_r     <= 1'b0;
      cnt_r         <= CNT_ZERO;
      clr_rx_rdy_r  <= 1'b0;
      cmd_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      shadow_r      <= shadow_nxt_s;
      cmd_r         <= cmd_nxt_s;
      cmd_rdy_r     <= cmd_rdy_nxt_s;
      cnt_r         <= cnt_nxt_s;
      clr_rx_rdy_r  <= capture_s;
      cmd_timeout_r <= timeout_s;
    end
  end

  // Receive FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_B1: begin
        if (capture_s) state_nxt_s = WAIT_B2;
        else           state_nxt_s = WAIT_B1;
      end
      WAIT_B2: begin
        if (capture_s)      state_nxt_s = WAIT_B3;
        else if (timeout_s) state_nxt_s = WAIT_B1;
        else                state_nxt_s = WAIT_B2;
      end
      WAIT_B3: begin
        if (capture_s)      state_nxt_s = CMD_HOLD;
        else if (timeout_s) state_nxt_s = WAIT_B1;
        else                state_nxt_s = WAIT_B3;
      end
      CMD_HOLD: begin
        if (clr_cmd_rdy) state_nxt_s = WAIT_B1;
        else             state_nxt_s = CMD_HOLD;
      end
      default: state_nxt_s = WAIT_B1;
    endcase
  end

  // Shadow lanes, command latch and inter-byte timer per state.
  always_comb begin
    shadow_nxt_s  = shadow_r;
    cmd_nxt_s     = cmd_r;
    cmd_rdy_nxt_s = cmd_rdy_r;
    cnt_nxt_s     = CNT_ZERO;
    case (state_r)
      WAIT_B1: begin
        if (capture_s) shadow_nxt_s = put_lane(shadow_r, 2'd0, rx_data);
        else           shadow_nxt_s = shadow_r;
      end
      WAIT_B2: begin
        if (capture_s)      shadow_nxt_s = put_lane(shadow_r, 2'd1, rx_data);
        else if (timeout_s) shadow_nxt_s = 24'h000000;
        else                cnt_nxt_s    = cnt_r + CNT_ONE;
      end
      WAIT_B3: begin
        if (capture_s) begin
          shadow_nxt_s  = put_lane(shadow_r, 2'd2, rx_data);
          cmd_nxt_s     = put_lane(shadow_r, 2'd2, rx_data);
          cmd_rdy_nxt_s = 1'b1;
        end else if (timeout_s) begin
          shadow_nxt_s = 24'h000000;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      CMD_HOLD: begin
        if (clr_cmd_rdy) cmd_rdy_nxt_s = 1'b0;
        else             cmd_rdy_nxt_s = cmd_rdy_r;
      end
      default: shadow_nxt_s = 24'h000000;
    endcase
  end

  assign clr_rx_rdy  = clr_rx_rdy_r;
  assign cmd         = cmd_r;
  assign cmd_rdy     = cmd_rdy_r;
  assign cmd_timeout = cmd_timeout_r;

  resp_tx_ctrl u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .resp_data (resp_data),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .resp_sent (resp_sent),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .trmt      (trmt)
  );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed corner sequences,
// a command vector table and randomized traffic against a queue-based model.
module tb_uart_cmd_assembler;
  localparam int TMO = 64;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_rdy, clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, cmd_timeout;
  logic [7:0]  resp_data, tx_data;
  logic        send_resp, resp_sent, tx_busy, trmt, tx_done;

  int tests = 0;
  int failed = 0;
  int clr_cnt = 0, tmo_cnt = 0, sent_cnt = 0, clr_double = 0;
  logic clr_prev = 1'b0;
  logic [7:0] host_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  b1, b2, b3;
    logic [23:0] exp_cmd;
  } vec_t;
  vec_t vecs[5];

  uart_cmd_assembler #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd_timeout(cmd_timeout),
    .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent),
    .tx_busy(tx_busy), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (clr_rx_rdy && clr_prev) clr_double <= clr_double + 1;
    clr_prev <= clr_rx_rdy;
    if (cmd_timeout) tmo_cnt <= tmo_cnt + 1;
    if (resp_sent) sent_cnt <= sent_cnt + 1;
  end

  // UART transmitter: tx_done stays stale for a cycle after trmt, then drops.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (trmt) begin
        host_q.push_back(tx_data);
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        tx_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    do begin step(); n++; end while (!clr_rx_rdy && n < 200);
    if (n >= 200) chk("byte_consumed", 32'(clr_rx_rdy), 32'd1);
    step();
    rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic wait_resp_sent();
    int n;
    n = 0;
    while (!resp_sent && n < 60) begin step(); n++; end
    chk("resp_sent_seen", 32'(resp_sent), 32'd1);
    chk("busy_clear_at_sent", 32'(tx_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_cmd"}, 32'(cmd), 32'd0);
    chk({name, "_flags"}, 32'({cmd_rdy, clr_rx_rdy, cmd_timeout, trmt, tx_busy, resp_sent}), 32'd0);
    chk({name, "_txd"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    int c0, t0, s0, part_n, exp_tmo, gap, n;
    logic [23:0] part_v;
    logic [7:0] b;

    vecs[0] = '{8'h01, 8'h00, 8'h03, 24'h010003};
    vecs[1] = '{8'h08, 8'h12, 8'h34, 24'h081234};
    vecs[2] = '{8'h09, 8'hFF, 8'hFF, 24'h09FFFF};
    vecs[3] = '{8'h07, 8'h00, 8'h00, 24'h070000};
    vecs[4] = '{8'hA5, 8'hEE, 8'h5A, 24'hA5EE5A};

    rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    resp_data = 8'h00; send_resp = 1'b0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Response path: accept, drop while busy, accept on the resp_sent cycle.
    s0 = sent_cnt;
    resp_data = 8'hA5; send_resp = 1'b1; step(); send_resp = 1'b0;
    exp_q.push_back(8'hA5);
    chk("trmt_pulse", 32'(trmt), 32'd1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    chk("tx_busy_set", 32'(tx_busy), 32'd1);
    resp_data = 8'hAB; send_resp = 1'b1; step(); send_resp = 1'b0;
    chk("trmt_one_cycle", 32'(trmt), 32'd0);
    chk("drop_keeps_data", 32'(tx_data), 32'hA5);
    chk("drop_still_busy", 32'(tx_busy), 32'd1);
    wait_resp_sent();
    resp_data = 8'h5A; send_resp = 1'b1; step(); send_resp = 1'b0;
    exp_q.push_back(8'h5A);
    chk("resp_sent_one_cycle", 32'(resp_sent), 32'd0);
    chk("accept_on_sent_trmt", 32'(trmt), 32'd1);
    chk("accept_on_sent_data", 32'(tx_data), 32'h5A);
    wait_resp_sent();
    step();
    chk("resp_sent_count", 32'(sent_cnt - s0), 32'd2);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      resp_data = b; send_resp = 1'b1; step(); send_resp = 1'b0;
      exp_q.push_back(b);
      wait_resp_sent();
    end
    step();
    chk("host_byte_count", 32'(host_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < host_q.size(); i++)
      chk("host_byte", 32'(host_q[i]), 32'(exp_q[i]));

    // Reset mid-command, then basic framing with latency check.
    send_byte(8'h08);
    rst = 1'b1; step(); rst = 1'b0;
    check_all_zero("mid_reset");
    c0 = clr_cnt;
    send_byte(8'h02);
    send_byte(8'h1C);
    rx_data = 8'h00; rx_rdy = 1'b1;
    chk("cmd_rdy_before", 32'(cmd_rdy), 32'd0);
    step();
    chk("b3_clr", 32'(clr_rx_rdy), 32'd1);
    chk("b3_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("frame_cmd", 32'(cmd), 32'h021C00);
    step();
    chk("clr_masks_rdy", 32'(clr_rx_rdy), 32'd0);
    rx_rdy = 1'b0;
    chk("three_clr_pulses", 32'(clr_cnt - c0), 32'd3);

    // Hold / back-pressure.
    c0 = clr_cnt;
    rx_data = 8'h09; rx_rdy = 1'b1;
    repeat (5) step();
    chk("hold_no_clr", 32'(clr_cnt - c0), 32'd0);
    chk("hold_cmd", 32'(cmd), 32'h021C00);
    chk("hold_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    chk("released_rdy", 32'(cmd_rdy), 32'd0);
    chk("no_same_cycle_capture", 32'(clr_rx_rdy), 32'd0);
    step();
    chk("pending_captured", 32'(clr_rx_rdy), 32'd1);
    step(); rx_rdy = 1'b0;
    send_byte(8'h2A); send_byte(8'h00);
    chk("hold_next_cmd", 32'(cmd), 32'h092A00);
    clear_cmd();

    // Inter-byte timeout fires exactly TMO cycles after the last capture.
    t0 = tmo_cnt;
    send_byte(8'h08); send_byte(8'h2A);
    repeat (TMO - 2) step();
    chk("tmo_not_early", 32'(cmd_timeout), 32'd0);
    step();
    chk("tmo_pulse", 32'(cmd_timeout), 32'd1);
    chk("tmo_no_rdy", 32'(cmd_rdy), 32'd0);
    chk("tmo_cmd_kept", 32'(cmd), 32'h092A00);
    step();
    chk("tmo_one_cycle", 32'(cmd_timeout), 32'd0);
    repeat (3) step();
    chk("tmo_count", 32'(tmo_cnt - t0), 32'd1);
    send_byte(8'h03); send_byte(8'h80); send_byte(8'h00);
    chk("after_tmo_cmd", 32'(cmd), 32'h038000);
    chk("after_tmo_rdy", 32'(cmd_rdy), 32'd1);
    clear_cmd();

    // Byte arriving on the terminal count beats the timeout.
    t0 = tmo_cnt;
    send_byte(8'h04); send_byte(8'h10);
    repeat (TMO - 2) step();
    rx_data = 8'h20; rx_rdy = 1'b1;
    step();
    chk("edge_capture", 32'(clr_rx_rdy), 32'd1);
    chk("edge_no_tmo", 32'(cmd_timeout), 32'd0);
    chk("edge_rdy", 32'(cmd_rdy), 32'd1);
    chk("edge_cmd", 32'(cmd), 32'h041020);
    step(); rx_rdy = 1'b0;
    repeat (3) step();
    chk("edge_tmo_count", 32'(tmo_cnt - t0), 32'd0);
    clear_cmd();

    // Vector table.
    foreach (vecs[i]) begin
      c0 = clr_cnt;
      send_byte(vecs[i].b1); send_byte(vecs[i].b2); send_byte(vecs[i].b3);
      chk("vec_rdy", 32'(cmd_rdy), 32'd1);
      chk("vec_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
      chk("vec_clr_pulses", 32'(clr_cnt - c0), 32'd3);
      clear_cmd();
    end

    // Randomized traffic: partial command is dropped when a gap exceeds TMO.
    t0 = tmo_cnt; c0 = clr_cnt;
    part_n = 0; part_v = 24'h0; exp_tmo = 0; n = 0;
    for (int i = 0; i < 30; i++) begin
      gap = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 130) : $urandom_range(0, 20);
      repeat (gap) step();
      if (part_n > 0 && gap >= 100) begin
        part_n = 0;
        exp_tmo++;
      end
      b = 8'($urandom);
      send_byte(b);
      n++;
      part_v = {part_v[15:0], b};
      part_n++;
      if (part_n == 3) begin
        chk("rand_rdy", 32'(cmd_rdy), 32'd1);
        chk("rand_cmd", 32'(cmd), 32'(part_v));
        clear_cmd();
        part_n = 0;
      end else begin
        chk("rand_no_rdy", 32'(cmd_rdy), 32'd0);
      end
    end
    repeat (100) step();
    if (part_n > 0) exp_tmo++;
    chk("rand_tmo_count", 32'(tmo_cnt - t0), 32'(exp_tmo));
    chk("rand_clr_count", 32'(clr_cnt - c0), 32'(n));
    chk("clr_never_double", 32'(clr_double), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
